// File: rtl/ysyx_22040632_lsu_pkg.sv
// Shared LSU types: access-size and FSM-state enums plus small size/alignment helpers.
package ysyx_22040632_RISCV_PKG;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} lsu_state_e;

    function automatic logic [3:0] lsu_nbytes(input lsu_size_e sz);
        return 4'd1 << sz;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] off, input lsu_size_e sz);
        logic [3:0] lsb_mask;
        lsb_mask = lsu_nbytes(sz) - 4'd1;
        return (({1'b0, off}) & lsb_mask) != 4'd0;
    endfunction

    // True when the access spills past the end of its 8-byte word.
    function automatic logic lsu_crosses(input logic [2:0] off, input lsu_size_e sz);
        return ({1'b0, off} + lsu_nbytes(sz)) > 4'd8;
    endfunction

endpackage

// File: rtl/ysyx_22040632_lsu_align.sv
// Combinational lane logic: byte strobes and write-data shift for both beats, load gather and extend.
module ysyx_22040632_lsu_align
    import ysyx_22040632_RISCV_PKG::*;
(
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata0_i,
    input  logic [63:0] rdata1_i,
    output logic [7:0]  wstrb0_o,
    output logic [7:0]  wstrb1_o,
    output logic [63:0] wdata0_o,
    output logic [63:0] wdata1_o,
    output logic [63:0] rdata_o
);

    logic [7:0]   size_mask;
    logic [15:0]  strb_wide;
    logic [127:0] wdata_wide;
    logic [63:0]  gathered;

    always_comb begin
        size_mask = 8'h00;
        case (lsu_size_e'(size_i))
            SZ_B:    size_mask = 8'h01;
            SZ_H:    size_mask = 8'h03;
            SZ_W:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Shifting into a double-width vector yields beat0 (low) and overflow beat1 (high) at once.
    assign strb_wide  = {8'h00, size_mask} << off_i;
    assign wdata_wide = {64'h0, wdata_i} << {off_i, 3'b000};
    assign wstrb0_o   = strb_wide[7:0];
    assign wstrb1_o   = strb_wide[15:8];
    assign wdata0_o   = wdata_wide[63:0];
    assign wdata1_o   = wdata_wide[127:64];

    assign gathered = 64'({rdata1_i, rdata0_i} >> {off_i, 3'b000});

    always_comb begin
        rdata_o = '0;
        case (lsu_size_e'(size_i))
            SZ_B:    rdata_o = {{56{~unsigned_i & gathered[7]}},  gathered[7:0]};
            SZ_H:    rdata_o = {{48{~unsigned_i & gathered[15]}}, gathered[15:0]};
            SZ_W:    rdata_o = {{32{~unsigned_i & gathered[31]}}, gathered[31:0]};
            default: rdata_o = gathered;
        endcase
    end

endmodule

// File: rtl/ysyx_22040632_lsu.sv
// Load/store unit: one outstanding EXU request mapped onto a valid/ready 8-byte-word data bus.
// YSYX_22040632_LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of splitting crossing ones.
module ysyx_22040632_lsu
    import ysyx_22040632_RISCV_PKG::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wstrb,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rsp_err
);

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [7:0]    wstrb0, wstrb1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] align_rdata0, align_rdata;
    logic [DW-1:0] load_data;
    logic [AW-1:0] word_addr;
    logic          beat1;
    logic          bus_write;

    ysyx_22040632_lsu_align u_align (
        .off_i      (addr_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata0_i   (align_rdata0),
        .rdata1_i   (mem_rdata),
        .wstrb0_o   (wstrb0),
        .wstrb1_o   (wstrb1),
        .wdata0_o   (wdata0),
        .wdata1_o   (wdata1),
        .rdata_o    (align_rdata)
    );

    // Beat0 data comes straight off the bus in RSP0; for a crossing load it was parked in rdata0_q.
    assign align_rdata0 = (state_q == RSP0) ? mem_rdata : rdata0_q;
    assign load_data    = we_q ? '0 : align_rdata;
    assign word_addr    = {addr_q[AW-1:3], 3'b000};

`ifdef YSYX_22040632_LSU_MISALIGN_TRAP_EN
    assign beat1 = 1'b0;
`else
    logic crossing;
    assign crossing = lsu_crosses(addr_q[2:0], lsu_size_e'(size_q));
    assign beat1    = (state_q == REQ1);
`endif

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = (state_q == DONE);
    assign resp_rdata    = rsp_rdata_q;
    assign resp_err      = rsp_err_q;
    assign mem_req_valid = (state_q == REQ0) || (state_q == REQ1);
    assign bus_write     = mem_req_valid & we_q;
    assign mem_we        = bus_write;
    assign mem_addr      = mem_req_valid ? (beat1 ? word_addr + AW'(8) : word_addr) : '0;
    assign mem_wdata     = bus_write ? (beat1 ? wdata1 : wdata0) : '0;
    assign mem_wstrb     = bus_write ? (beat1 ? wstrb1 : wstrb0) : '0;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata0_d    = rdata0_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rdata0_d    = '0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
`ifdef YSYX_22040632_LSU_MISALIGN_TRAP_EN
                    if (lsu_misaligned(req_addr[2:0], lsu_size_e'(req_size))) begin
                        state_d   = DONE;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = REQ0;
                    end
`else
                    state_d = REQ0;
`endif
                end
            end
            REQ0: begin
                if (mem_req_ready) state_d = RSP0;
            end
            RSP0: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        state_d     = DONE;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
`ifndef YSYX_22040632_LSU_MISALIGN_TRAP_EN
                    end else if (crossing) begin
                        rdata0_d = mem_rdata;
                        state_d  = REQ1;
`endif
                    end else begin
                        state_d     = DONE;
                        rsp_rdata_d = load_data;
                    end
                end
            end
`ifndef YSYX_22040632_LSU_MISALIGN_TRAP_EN
            REQ1: begin
                if (mem_req_ready) state_d = RSP1;
            end
            RSP1: begin
                if (mem_rsp_valid) begin
                    state_d     = DONE;
                    rsp_err_d   = mem_rsp_err;
                    rsp_rdata_d = mem_rsp_err ? '0 : load_data;
                end
            end
`endif
            DONE: begin
                state_d     = IDLE;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata0_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata0_q    <= rdata0_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
